core_ctrl: RTL
==============

CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameter: col, 8, number of weight vectors loaded per layer (weight-phase length).
REQ-002 Parameter: addr_bw, 11, SRAM address width; all address arithmetic is modulo 2^addr_bw.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  one-cycle request to run one layer; sampled only in IDLE.
REQ-006 Port: w_base  input  addr_bw  xmem address of the first weight vector.
REQ-007 Port: x_base  input  addr_bw  xmem address of the first activation vector.
REQ-008 Port: p_base  input  addr_bw  psum memory address of the first output.
REQ-009 Port: len  input  addr_bw  number of activation vectors (and psum outputs); valid range 1..2047.
REQ-010 Port: acc_en  input  1  accumulate flag, driven on inst[33] during DRAIN.
REQ-011 Port: ofifo_valid  input  1  corelet output FIFO holds a psum vector.
REQ-012 Port: inst  output  34  instruction word to core; decode: [33] acc, [32] psum CEN, [31] psum WEN, [30:20] psum addr, [19] xmem CEN, [18] xmem WEN, [17:7] xmem addr, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: done  output  1  one-cycle pulse on completion.

Function
REQ-015 start, w_base, x_base, p_base, len and acc_en SHALL be registered when start=1 in IDLE with len!=0; start with len=0 or outside IDLE SHALL be ignored.
REQ-016 FSM states: IDLE -> W_RD -> W_LD -> X_RD -> EXEC -> DRAIN -> DONE -> IDLE; no other transitions except reset.
REQ-017 Idle word: CENs=1, WENs=1, addresses=0, all other bits 0; this word SHALL be driven in IDLE, DONE, and any cycle without a listed action.
REQ-018 xmem reads have 1-cycle latency: a read issued in cycle t is consumed by l0_wr in cycle t+1.
REQ-019 W_RD: col+1 cycles; cycle k<col issues xmem read (CEN=0, WEN=1) at w_base+k; l0_wr=1 in cycles 1..col.
REQ-020 W_LD: col cycles with l0_rd=1 and load=1.
REQ-021 X_RD: len+1 cycles; cycle k<len issues xmem read at x_base+k; l0_wr=1 in cycles 1..len.
REQ-022 EXEC: len cycles with l0_rd=1 and execute=1.
REQ-023 DRAIN: in each cycle with ofifo_valid=1, drive ofifo_rd=1, psum CEN=0, WEN=0, address p_base+n, acc=acc_en; n increments per write; no write when ofifo_valid=0.
REQ-024 DRAIN exits to DONE in the cycle after the len-th write; ofifo_valid after that is ignored.
REQ-025 DONE lasts exactly one cycle with done=1, busy=1; then IDLE.
REQ-026 Address sums wrapping past 2^addr_bw-1 SHALL continue from 0.
REQ-027 inst, busy and done SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-028 reset=0 SHALL immediately force IDLE, clear all counters and latched parameters, inst=idle word, busy=0, done=0, including mid-operation.
REQ-029 After reset release, the first start is accepted on the next rising edge with reset=1.

Verification
REQ-030 col=8, w_base=0, x_base=16, len=4, ofifo_valid tied 1 -> reads 0..7, l0_wr 8 cycles, load 8 cycles, reads 16..19, execute 4 cycles, psum writes 0..3, done pulse.
REQ-031 ofifo_valid toggling 1,0,0,1,1,0,1 during DRAIN with len=4 -> exactly 4 psum writes at consecutive addresses, only on valid cycles.
REQ-032 x_base=2046, len=4, p_base=2047 -> xmem reads 2046,2047,0,1; psum writes 2047,0,1,2.
REQ-033 reset=0 asserted mid-EXEC -> same-cycle idle word, busy=0; a new start then runs cleanly from W_RD.
REQ-034 start with len=0, and start while busy -> ignored, no state change.
REQ-035 acc_en=1 -> inst[33]=1 only on DRAIN write cycles, 0 elsewhere.

Source files
------------

// File: rtl/core_ctrl.sv
// core_ctrl: sequencer for one layer of the core.
// It loads col weight vectors from xmem into L0 and pushes them into the
// array. It then streams len activation vectors through L0 and executes
// them. Finally it drains len psum vectors from the output FIFO into psum
// memory.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-low
//   start        one-cycle layer request (honoured only in IDLE with len != 0)
//   w_base       xmem address of first weight vector
//   x_base       xmem address of first activation vector
//   p_base       psum address of first output
//   len          activation / output count (1..2^addr_bw-1)
//   acc_en       accumulate flag carried on inst[33] for psum writes
//   ofifo_valid  output FIFO has a psum vector ready
//   inst         registered instruction word to the core
//   busy         registered, high outside IDLE
//   done         registered one-cycle completion pulse
//
// state   | meaning
// IDLE    | waiting for start, idle word
// W_RD    | col weight reads from xmem, L0 write trails each read by a cycle
// W_LD    | col cycles of l0_rd + load
// X_RD    | len activation reads, L0 write trails each read by a cycle
// EXEC    | len cycles of l0_rd + execute
// DRAIN   | one psum write per valid FIFO entry until len writes are done
// DONE    | single cycle with done=1
module core_ctrl #(
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw-1:0]     w_base,
  input  logic [addr_bw-1:0]     x_base,
  input  logic [addr_bw-1:0]     p_base,
  input  logic [addr_bw-1:0]     len,
  input  logic                   acc_en,
  input  logic                   ofifo_valid,
  output logic [2*addr_bw+11:0]  inst,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_RD, S_W_LD, S_X_RD, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  localparam logic [addr_bw-1:0] C_COL  = addr_bw'(col);
  localparam logic [addr_bw-1:0] C_ONE  = addr_bw'(1);
  localparam logic [addr_bw-1:0] C_ZERO = '0;
  localparam logic [2*addr_bw+11:0] IDLE_WORD =
    {1'b0, 1'b1, 1'b1, C_ZERO, 1'b1, 1'b1, C_ZERO, 7'b0};

  state_t             r_state, w_state_nxt;
  logic [addr_bw-1:0] r_k, w_k_nxt, w_pidx;
  logic [addr_bw-1:0] r_w_base, r_x_base, r_p_base, r_len;
  logic               r_acc;
  logic               w_wr_nxt, w_load_par;
  logic [addr_bw-1:0] w_wb, w_xb, w_pb, w_ln;
  logic               w_acc;
  logic               w_xrd, w_l0_wr, w_load, w_exec;
  logic [addr_bw-1:0] w_xaddr, w_paddr;
  logic [2*addr_bw+11:0] w_inst_nxt;
  logic               w_busy_nxt, w_done_nxt;

  // Outputs are registered from next-cycle values, so the parameters seen by
  // the output logic must already be the ones being latched on a start edge.
  assign w_wb  = w_load_par ? w_base : r_w_base;
  assign w_xb  = w_load_par ? x_base : r_x_base;
  assign w_pb  = w_load_par ? p_base : r_p_base;
  assign w_ln  = w_load_par ? len    : r_len;
  assign w_acc = w_load_par ? acc_en : r_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_w_base <= '0;
      r_x_base <= '0;
      r_p_base <= '0;
      r_len    <= '0;
      r_acc    <= 1'b0;
      inst     <= IDLE_WORD;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      if (w_load_par) begin
        r_w_base <= w_base;
        r_x_base <= x_base;
        r_p_base <= p_base;
        r_len    <= len;
        r_acc    <= acc_en;
      end
      inst <= w_inst_nxt;
      busy <= w_busy_nxt;
      done <= w_done_nxt;
    end
  end

  // In DRAIN, r_k counts writes already presented on inst; the next write
  // (if the FIFO is valid at this edge) goes to p_base + r_k.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_wr_nxt    = 1'b0;
    w_load_par  = 1'b0;
    w_pidx      = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start && (len != C_ZERO)) begin
          w_state_nxt = S_W_RD;
          w_k_nxt     = '0;
          w_load_par  = 1'b1;
        end
      end
      S_W_RD: begin
        if (r_k == C_COL) begin
          w_state_nxt = S_W_LD;
          w_k_nxt     = '0;
        end else w_k_nxt = r_k + C_ONE;
      end
      S_W_LD: begin
        if (r_k == C_COL - C_ONE) begin
          w_state_nxt = S_X_RD;
          w_k_nxt     = '0;
        end else w_k_nxt = r_k + C_ONE;
      end
      S_X_RD: begin
        if (r_k == r_len) begin
          w_state_nxt = S_EXEC;
          w_k_nxt     = '0;
        end else w_k_nxt = r_k + C_ONE;
      end
      S_EXEC: begin
        if (r_k == r_len - C_ONE) begin
          w_state_nxt = S_DRAIN;
          w_wr_nxt    = ofifo_valid;
          w_k_nxt     = {{(addr_bw-1){1'b0}}, ofifo_valid};
        end else w_k_nxt = r_k + C_ONE;
      end
      S_DRAIN: begin
        if (r_k == r_len) begin
          w_state_nxt = S_DONE;
          w_k_nxt     = '0;
        end else begin
          w_wr_nxt = ofifo_valid;
          w_pidx   = r_k;
          w_k_nxt  = r_k + {{(addr_bw-1){1'b0}}, ofifo_valid};
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = '0;
      end
    endcase
  end

  always_comb begin
    w_xrd   = 1'b0;
    w_xaddr = '0;
    w_l0_wr = 1'b0;
    w_load  = 1'b0;
    w_exec  = 1'b0;
    w_paddr = '0;
    unique case (w_state_nxt)
      S_W_RD: begin
        w_xrd   = (w_k_nxt != C_COL);
        w_l0_wr = (w_k_nxt != C_ZERO);
        if (w_xrd) w_xaddr = w_wb + w_k_nxt;
      end
      S_X_RD: begin
        w_xrd   = (w_k_nxt != w_ln);
        w_l0_wr = (w_k_nxt != C_ZERO);
        if (w_xrd) w_xaddr = w_xb + w_k_nxt;
      end
      S_W_LD:  w_load = 1'b1;
      S_EXEC:  w_exec = 1'b1;
      S_DRAIN: if (w_wr_nxt) w_paddr = w_pb + w_pidx;
      default: ;
    endcase
    w_inst_nxt = {w_wr_nxt & w_acc, ~w_wr_nxt, ~w_wr_nxt, w_paddr,
                  ~w_xrd, 1'b1, w_xaddr,
                  w_wr_nxt, 1'b0, 1'b0, w_load | w_exec, w_l0_wr, w_exec, w_load};
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

endmodule
